// File: rtl/flash_spi_read_arbiter_pkg.sv
// Shared types and constants for the two-port SPI flash read arbiter.
`default_nettype none

package flash_spi_read_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SEND     = 3'd2,
    ST_DUMMY    = 3'd3,
    ST_RECV     = 3'd4,
    ST_CS_HOLD  = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  localparam int         FRAME_OUT_BITS   = 32;
  localparam int         FRAME_IN_BITS    = 32;
  localparam logic [7:0] DEFAULT_READ_CMD = 8'h03;

  // Flash streams the lowest-addressed byte first; the core wants it in [7:0].
  function automatic logic [31:0] byte_swap32(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/flash_spi_read_arbiter_spi_clk_gen.sv
// Mode-0 SPI clock generator: CLK_DIV system clocks per half-period, idles low when disabled.
`default_nettype none

module flash_spi_read_arbiter_spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic spi_clk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int                 CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] half_cnt;
  logic             half_done;

  assign half_done = enable && (half_cnt == CNT_LAST);
  assign rise_tick = half_done && !spi_clk;
  assign fall_tick = half_done && spi_clk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_cnt <= '0;
      spi_clk  <= 1'b0;
    end else if (!enable) begin
      half_cnt <= '0;
      spi_clk  <= 1'b0;
    end else if (half_done) begin
      half_cnt <= '0;
      spi_clk  <= !spi_clk;
    end else begin
      half_cnt <= half_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/flash_spi_read_arbiter.sv
// Round-robin arbiter serving 32-bit word reads from SPI flash for two requesters.
`default_nettype none

module flash_spi_read_arbiter
  import flash_spi_read_arbiter_pkg::*;
#(
  parameter int         CLK_DIV    = 2,
  parameter int         DUMMY_BITS = 1,
  parameter logic [7:0] READ_CMD   = DEFAULT_READ_CMD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic        req0_ready,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  output logic        req1_ready,
  output logic [31:0] req1_rdata,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int                   BIT_CNT_W  = 6;
  localparam logic [BIT_CNT_W-1:0] SEND_LAST  = BIT_CNT_W'(FRAME_OUT_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] DUMMY_LAST = BIT_CNT_W'((DUMMY_BITS > 0) ? DUMMY_BITS - 1 : 0);
  localparam logic [BIT_CNT_W-1:0] RECV_LAST  = BIT_CNT_W'(FRAME_IN_BITS - 1);
  localparam state_t               AFTER_SEND = (DUMMY_BITS == 0) ? ST_RECV : ST_DUMMY;

  state_t               state;
  state_t               state_next;
  logic                 rr_ptr;
  logic                 port_sel;
  logic                 grant;
  logic                 grant_port;
  logic [23:0]          grant_addr;
  logic [31:0]          shift_reg;
  logic [31:0]          rx_reg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 clk_en;
  logic                 rise_tick;
  logic                 fall_tick;
  logic                 unused_addr_lsbs;

  flash_spi_read_arbiter_spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_spi_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .enable    (clk_en),
    .spi_clk   (spi_clk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign grant_addr       = grant_port ? req1_addr : req0_addr;
  assign unused_addr_lsbs = ^grant_addr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    clk_en     = 1'b0;
    spi_cs_n   = 1'b1;
    spi_mosi   = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        // rr_ptr == 0 favours port 0 when both request together
        if (req0_valid && (!req1_valid || !rr_ptr)) begin
          grant      = 1'b1;
          grant_port = 1'b0;
          state_next = ST_CS_SETUP;
        end else if (req1_valid) begin
          grant      = 1'b1;
          grant_port = 1'b1;
          state_next = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        spi_cs_n   = 1'b0;
        spi_mosi   = shift_reg[31];
        state_next = ST_SEND;
      end
      ST_SEND: begin
        spi_cs_n = 1'b0;
        spi_mosi = shift_reg[31];
        clk_en   = 1'b1;
        if (fall_tick && (bit_cnt == SEND_LAST)) begin
          state_next = AFTER_SEND;
        end
      end
      ST_DUMMY: begin
        spi_cs_n = 1'b0;
        spi_mosi = 1'b1;
        clk_en   = 1'b1;
        if (fall_tick && (bit_cnt == DUMMY_LAST)) begin
          state_next = ST_RECV;
        end
      end
      ST_RECV: begin
        spi_cs_n = 1'b0;
        clk_en   = 1'b1;
        if (fall_tick && (bit_cnt == RECV_LAST)) begin
          state_next = ST_CS_HOLD;
        end
      end
      ST_CS_HOLD: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Bit counter restarts on every phase change so each phase counts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
    end else if (state != state_next) begin
      bit_cnt <= '0;
    end else if (fall_tick) begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= 1'b0;
      port_sel   <= 1'b0;
      shift_reg  <= '0;
      rx_reg     <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      if (grant) begin
        port_sel  <= grant_port;
        rr_ptr    <= !grant_port;
        shift_reg <= {READ_CMD, grant_addr[23:2], 2'b00};
      end
      if ((state == ST_SEND) && fall_tick) begin
        shift_reg <= {shift_reg[30:0], 1'b0};
      end
      if ((state == ST_RECV) && rise_tick) begin
        rx_reg <= {rx_reg[30:0], spi_miso};
      end
      // Results land on the edge entering DONE so ready and rdata are valid together.
      if (state == ST_CS_HOLD) begin
        if (port_sel) begin
          req1_rdata <= byte_swap32(rx_reg);
          req1_ready <= 1'b1;
        end else begin
          req0_rdata <= byte_swap32(rx_reg);
          req0_ready <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
